label_resolver: RTL

Second-pass companion to the connected-components labeller. Once a frame is labelled, it reads the labeller's merge table (entry `i` holds the parent label of `i`, with parent ≤ `i`). It resolves every provisional label to a compact final object ID, 1..N, and stores the results in an internal resolved table. During the relabel pass it answers per-pixel lookups from that table.

---
 rtl/label_resolver.sv | 93 +++++++++
 1 files changed

// File: rtl/label_resolver.sv
// Second pass of connected-components labelling: walks the merge table once,
// assigns compact object IDs 1..N to roots, and serves per-pixel ID lookups.
module label_resolver #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_labels,
    output logic [WORD_SIZE-1:0] mt_addr,
    input  logic [WORD_SIZE-1:0] mt_data,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] num_objects,
    output logic                 error,
    input  logic                 lookup_en,
    input  logic [WORD_SIZE-1:0] lookup_label,
    output logic [WORD_SIZE-1:0] lookup_q
);

    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

    typedef enum logic [1:0] {IDLE, FETCH, RESOLVE, DONE} state_t;

    state_t               state, state_nx;
    logic [WORD_SIZE-1:0] n_q;
    logic [WORD_SIZE-1:0] idx;
    logic [WORD_SIZE-1:0] tbl [0:(1<<WORD_SIZE)-1];

    logic linked, bad, last;

    // Parent strictly below us points at an already-resolved label; anything
    // else is a root, malformed or not.
    assign linked = (mt_data != '0) && (mt_data < idx);
    assign bad    = (mt_data == '0) || (mt_data > idx);
    assign last   = (idx == n_q - ONE);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_labels <= ONE) ? DONE : FETCH;
            FETCH:   state_nx = RESOLVE;
            RESOLVE: state_nx = last ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            n_q         <= '0;
            idx         <= '0;
            num_objects <= '0;
            error       <= 1'b0;
            mt_addr     <= '0;
            lookup_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    n_q         <= num_labels;
                    idx         <= ONE;
                    num_objects <= '0;
                    error       <= 1'b0;
                    // Address is presented during FETCH, so load it on entry.
                    if (num_labels > ONE) mt_addr <= ONE;
                end
                RESOLVE: begin
                    if (!linked) num_objects <= num_objects + ONE;
                    if (bad)     error       <= 1'b1;
                    if (!last) begin
                        idx     <= idx + ONE;
                        mt_addr <= idx + ONE;
                    end
                end
                default: ;
            endcase
            if (lookup_en)
                lookup_q <= (lookup_label == '0) ? '0 : tbl[lookup_label];
        end
    end

    // Resolved table is deliberately not reset; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (state == RESOLVE)
            tbl[idx] <= linked ? tbl[mt_data] : num_objects + ONE;
    end

endmodule
